load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles waiting for bus_ack_i before an error (0 = no timeout).
REQ-002 SHALL have ports (name direction width meaning):
- clk_i  in  1  single clock; all logic on rising edge.
- reset_i  in  1  reset, synchronous, active-high.
- req_i  in  1  access request from core; sampled only in IDLE.
- we_i  in  1  1 = store, 0 = load.
- addr_i  in  32  byte address.
- mask_i  in  4  size: 0001 byte, 0011 half, 1111 word.
- sext_i  in  1  sign-extend load data.
- wdata_i  in  32  store data, LSB-justified.
- busy_o  out  1  high whenever state is not IDLE.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  qualifies done_o: misaligned, illegal mask or timeout.
- rdata_o  out  32  load result, held until the next done_o.
- bus_req_o  out  1  bus request.
- bus_ack_i  in  1  bus acknowledge; completes the transfer.
- bus_we_o  out  1  bus write enable.
- bus_addr_o  out  32  word-aligned bus address.
- bus_be_o  out  4  bus byte enables.
- bus_wdata_o  out  32  lane-aligned store data.
- bus_rdata_i  in  32  bus read data, valid with bus_ack_i.

Function
REQ-003 SHALL implement the states IDLE, BUS and RESP.
REQ-004 In IDLE, req_i=1 SHALL latch we_i, addr_i, mask_i, sext_i and wdata_i; req_i SHALL be ignored in BUS and RESP.
REQ-005 A request SHALL be an error when any of the following holds:
- mask_i is not 0001, 0011 or 1111.
- mask_i=0011 with addr_i[0]=1.
- mask_i=1111 with addr_i[1:0]!=00.
REQ-006 An error request SHALL go IDLE->RESP with no bus activity; done_o=1, err_o=1 and rdata_o=0 in the next cycle.
REQ-007 A legal request SHALL go IDLE->BUS; bus_req_o=1 from the next cycle with:
- bus_addr_o = {addr[31:2],00}.
- bus_be_o = mask<<addr[1:0].
- bus_wdata_o = wdata<<(8*addr[1:0]).
- bus_we_o = we.
REQ-008 bus_req_o and all bus outputs SHALL stay constant in BUS until the cycle bus_ack_i=1.
REQ-009 On bus_ack_i=1 in BUS, the block SHALL capture bus_rdata_i, go to RESP and drop bus_req_o the next cycle.
REQ-010 bus_ack_i SHALL be ignored outside BUS.
REQ-011 Load data SHALL be formed as follows:
- Shift bus_rdata_i right by 8*addr[1:0].
- Truncate to 8/16/32 bits per mask.
- Fill upper bits with the MSB of the truncated value if sext=1, else zero.
REQ-012 A store SHALL set rdata_o=0 at done_o.
REQ-013 A cycle counter SHALL count cycles in BUS; when it reaches TIMEOUT_CYCLES (nonzero) with no ack, the block SHALL go to RESP with err_o=1 and rdata_o=0, dropping bus_req_o.
REQ-014 An ack in the same cycle as the timeout SHALL win (no error).
REQ-015 RESP SHALL last exactly one cycle with done_o=1, then return to IDLE; done_o and err_o SHALL be 0 in every other cycle.
REQ-016 Latency: for a request in cycle N and an ack in cycle M (M>=N+1), done_o SHALL be high in cycle M+1; the minimum legal-access latency is 2 cycles.
REQ-017 A new request SHALL be accepted in the cycle after done_o (back-to-back).
REQ-018 busy_o SHALL be 1 in BUS and RESP and 0 in IDLE.

Reset
REQ-019 With reset_i=1 at a clock edge, the following SHALL hold after that edge, including mid-transaction:
- State is IDLE.
- The timeout counter is 0.
- All outputs (busy_o, done_o, err_o, rdata_o, bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o) are 0.
REQ-020 No done_o SHALL be produced for an access aborted by reset.

Verification
REQ-021 The bench SHALL cover at least these directed scenarios (stimulus -> required response):
- LB, addr=0x1003, sext=1; ack with rdata=0x80FFFFFF -> bus_addr=0x1000, be=1000, rdata_o=0xFFFFFF80, err=0.
- LHU, addr=0x2002; rdata=0xBEEF1234 -> be=1100, rdata_o=0x0000BEEF.
- SB, addr=0x3001, wdata=0x000000AB -> bus_we=1, be=0010, bus_wdata=0x0000AB00, rdata_o=0.
- LW, addr=0x4002 -> no bus_req_o; done_o=1, err_o=1 one cycle after the request.
- TIMEOUT_CYCLES=4, no ack -> bus_req_o high 4 cycles, then done_o=1, err_o=1.
- reset_i=1 in the 2nd BUS cycle, then a new LW with 0-cycle-wait ack -> outputs 0 after reset; the new LW completes with done_o 2 cycles after req_i.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word core accesses into word-aligned bus
// transfers with lane steering, load extension and a bus-ack timeout.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  mask_i,
    input  logic        sext_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        bus_req_o,
    input  logic        bus_ack_i,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_addr_lo;
    logic [3:0]         r_mask;
    logic               r_sext;

    logic               w_req_err;
    logic               w_timeout;
    logic [31:0]        w_shifted;
    logic [31:0]        w_ld_data;

    // Request legality and load-data formatting
    always_comb begin
        w_req_err = 1'b0;
        case (mask_i)
            4'b0001: w_req_err = 1'b0;
            4'b0011: w_req_err = addr_i[0];
            4'b1111: w_req_err = (addr_i[1:0] != 2'b00);
            default: w_req_err = 1'b1;
        endcase

        w_shifted = bus_rdata_i >> {r_addr_lo, 3'b000};
        w_ld_data = w_shifted;
        case (r_mask)
            4'b0001: w_ld_data = {{24{r_sext & w_shifted[7]}},  w_shifted[7:0]};
            4'b0011: w_ld_data = {{16{r_sext & w_shifted[15]}}, w_shifted[15:0]};
            default: w_ld_data = w_shifted;
        endcase

        w_timeout = (TIMEOUT_CYCLES != 0) &&
                    (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    // Control FSM with registered outputs; an ack in the timeout cycle wins
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_addr_lo   <= '0;
            r_mask      <= '0;
            r_sext      <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            rdata_o     <= '0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= '0;
            bus_wdata_o <= '0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_i) begin
                        r_addr_lo <= addr_i[1:0];
                        r_mask    <= mask_i;
                        r_sext    <= sext_i;
                        busy_o    <= 1'b1;
                        if (w_req_err) begin
                            r_state <= RESP;
                            done_o  <= 1'b1;
                            err_o   <= 1'b1;
                            rdata_o <= '0;
                        end else begin
                            r_state     <= BUS;
                            r_cnt       <= '0;
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= we_i;
                            bus_addr_o  <= {addr_i[31:2], 2'b00};
                            bus_be_o    <= mask_i << addr_i[1:0];
                            bus_wdata_o <= wdata_i << {addr_i[1:0], 3'b000};
                        end
                    end
                end
                BUS: begin
                    if (bus_ack_i) begin
                        r_state   <= RESP;
                        bus_req_o <= 1'b0;
                        done_o    <= 1'b1;
                        rdata_o   <= bus_we_o ? 32'd0 : w_ld_data;
                    end else if (w_timeout) begin
                        r_state   <= RESP;
                        bus_req_o <= 1'b0;
                        done_o    <= 1'b1;
                        err_o     <= 1'b1;
                        rdata_o   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    busy_o  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
